// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines and deframes
// 11-bit device-to-host frames. Each accepted make code is presented with
// a one-cycle strobe. Break (F0 xx) and extended (E0) prefixes can be filtered.
module ps2_key_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          FILTER_BREAK   = 1'b1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic       frame_error
);

    localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_RAW > 16) ? TW_RAW : 16;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    // The start bit is consumed by the IDLE edge check, so no separate START state.
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          break_pending_q, break_pending_d;
    logic [7:0]    key_data_q, key_data_d;
    logic          pressed_q, pressed_d;
    logic          error_q, error_d;
    logic          fall;
    logic          frame_ok;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Deframing, filtering and timeout decisions.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        parity_d        = parity_q;
        break_pending_d = break_pending_q;
        key_data_d      = key_data_q;
        pressed_d       = 1'b0;
        error_d         = 1'b0;

        fall     = clk_prev_q & ~clk_sync_q;
        frame_ok = (^{shift_q, parity_q}) & dat_sync_q;
        tmo_d    = (fall || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (fall && !dat_sync_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    parity_d = dat_sync_q;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        error_d = 1'b1;
                    end else if (!FILTER_BREAK) begin
                        key_data_d = shift_q;
                        pressed_d  = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        break_pending_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        break_pending_d = break_pending_q;
                    end else if (break_pending_q) begin
                        break_pending_d = 1'b0;
                    end else begin
                        key_data_d = shift_q;
                        pressed_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && !fall && tmo_q == TMO_LIMIT) begin
            state_d   = S_IDLE;
            error_d   = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
        end
    end

    // Frame state, timeout counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            parity_q        <= 1'b0;
            tmo_q           <= '0;
            break_pending_q <= 1'b0;
            key_data_q      <= 8'h00;
            pressed_q       <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            tmo_q           <= tmo_d;
            break_pending_q <= break_pending_d;
            key_data_q      <= key_data_d;
            pressed_q       <= pressed_d;
            error_q         <= error_d;
        end
    end

    assign ps2_key_data    = key_data_q;
    assign ps2_key_pressed = pressed_q;
    assign frame_error     = error_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: one filtering and one raw instance share the
// PS/2 lines; observed strobes are compared against a frame-level model.
module tb_ps2_key_receiver;

    localparam int unsigned T = 300;

    typedef struct packed {
        logic        err;
        logic [7:0]  data;
        int unsigned cyc;
    } ev_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] data0, data1;
    logic       pressed0, pressed1, err0, err1;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    ev_t obs0[$], obs1[$], exp0[$], exp1[$];

    // reference model state
    bit          m_recv = 1'b0;
    int unsigned m_n = 0;
    logic [9:0]  m_bits = '0;
    bit          m_bp = 1'b0;
    logic [7:0]  m_data0 = 8'h00, m_data1 = 8'h00;
    int unsigned m_last_d = 0;

    ps2_key_receiver #(.TIMEOUT_CYCLES(T), .FILTER_BREAK(1'b0)) dut0 (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .ps2_key_data(data0), .ps2_key_pressed(pressed0), .frame_error(err0));

    ps2_key_receiver #(.TIMEOUT_CYCLES(T), .FILTER_BREAK(1'b1)) dut1 (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .ps2_key_data(data1), .ps2_key_pressed(pressed1), .frame_error(err1));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (pressed0) obs0.push_back('{1'b0, data0, cyc});
        if (err0)     obs0.push_back('{1'b1, 8'h00, cyc});
        if (pressed1) obs1.push_back('{1'b0, data1, cyc});
        if (err1)     obs1.push_back('{1'b1, 8'h00, cyc});
        if (pressed0 || err0) check_eq("excl0", 32'(pressed0 & err0), 0);
        if (pressed1 || err1) check_eq("excl1", 32'(pressed1 & err1), 0);
    end

    // A complete frame: start 0, 8 data bits, parity bit, stop bit.
    task automatic model_frame(input int unsigned d);
        logic [7:0] b;
        bit ok;
        b  = m_bits[7:0];
        ok = (^m_bits[8:0]) && m_bits[9];
        if (!ok) begin
            exp0.push_back('{1'b1, 8'h00, d + 3});
            exp1.push_back('{1'b1, 8'h00, d + 3});
        end else begin
            exp0.push_back('{1'b0, b, d + 3});
            m_data0 = b;
            if (b == 8'hF0)      m_bp = 1'b1;
            else if (b == 8'hE0) m_bp = m_bp;
            else if (m_bp)       m_bp = 1'b0;
            else begin
                exp1.push_back('{1'b0, b, d + 3});
                m_data1 = b;
            end
        end
    endtask

    task automatic model_edge(input bit v, input int unsigned d);
        m_last_d = d;
        if (!m_recv) begin
            if (v == 1'b0) begin
                m_recv = 1'b1;
                m_n    = 0;
            end
        end else begin
            m_bits[m_n] = v;
            m_n++;
            if (m_n == 10) begin
                m_recv = 1'b0;
                model_frame(d);
            end
        end
    endtask

    task automatic drive_bit(input bit v);
        int unsigned half;
        half = $urandom_range(8, 40);
        @(negedge clock);
        ps2_dat = v;
        repeat (half) @(negedge clock);
        ps2_clk = 1'b0;
        model_edge(v, cyc);
        repeat (half) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int unsigned nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i < int'(nbits)) drive_bit(f[i]);
        end
    endtask

    // Idle well past the timeout; an open frame must be abandoned with an error.
    task automatic idle_long();
        repeat (T + 40) @(negedge clock);
        if (m_recv) begin
            exp0.push_back('{1'b1, 8'h00, m_last_d + T + 3});
            exp1.push_back('{1'b1, 8'h00, m_last_d + T + 3});
            m_recv = 1'b0;
        end
    endtask

    task automatic compare_step(input string tag);
        int unsigned n;
        repeat (8) @(negedge clock);
        check_eq({tag, ".n0"}, obs0.size(), exp0.size());
        check_eq({tag, ".n1"}, obs1.size(), exp1.size());
        n = (obs0.size() < exp0.size()) ? obs0.size() : exp0.size();
        for (int i = 0; i < int'(n); i++) begin
            check_eq({tag, ".ev0"}, {obs0[i].err, obs0[i].data, obs0[i].cyc[22:0]},
                                    {exp0[i].err, exp0[i].data, exp0[i].cyc[22:0]});
        end
        n = (obs1.size() < exp1.size()) ? obs1.size() : exp1.size();
        for (int i = 0; i < int'(n); i++) begin
            check_eq({tag, ".ev1"}, {obs1[i].err, obs1[i].data, obs1[i].cyc[22:0]},
                                    {exp1[i].err, exp1[i].data, exp1[i].cyc[22:0]});
        end
        check_eq({tag, ".data0"}, 32'(data0), 32'(m_data0));
        check_eq({tag, ".data1"}, 32'(data1), 32'(m_data1));
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        m_recv = 1'b0; m_bp = 1'b0; m_data0 = 8'h00; m_data1 = 8'h00;
        check_eq("rst.out0", {24'h0, data0, 7'h0, pressed0, err0}, 0);
        check_eq("rst.out1", {24'h0, data1, 7'h0, pressed1, err1}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int unsigned r;
        repeat (4) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check_eq("reset0", {24'h0, data0, 7'h0, pressed0, err0}, 0);
        check_eq("reset1", {24'h0, data1, 7'h0, pressed1, err1}, 0);

        send_frame(8'h1D, 0, 0, 11);                 compare_step("make1d");
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h1D, 0, 0, 11);                 compare_step("break1d");
        send_frame(8'h1D, 0, 0, 11);                 compare_step("again1d");
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 11);                 compare_step("ext75");
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 11);                 compare_step("extbrk75");
        send_frame(8'h1B, 1, 0, 11);                 compare_step("badpar");
        send_frame(8'h1B, 0, 1, 11);                 compare_step("badstop");
        send_frame(8'h1B, 0, 0, 5);  idle_long();    compare_step("timeout");
        send_frame(8'h1B, 0, 0, 11);                 compare_step("after_tmo");
        send_frame(8'h5A, 0, 0, 5);
        pulse_reset();
        for (int i = 4; i < 10; i++) begin
            drive_bit((i < 8) ? b_bit(8'h5A, i) : ((i == 8) ? ~^8'h5A : 1'b1));
        end
        idle_long();                                 compare_step("midrst");
        send_frame(8'h23, 0, 0, 11);                 compare_step("after_rst");

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 5);
            b = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
            r = $urandom_range(0, 15);
            if (r < 2) begin
                send_frame(b, 0, 0, $urandom_range(1, 10));
                idle_long();
            end else begin
                send_frame(b, r == 2, r == 3, 11);
            end
            repeat ($urandom_range(0, 30)) @(negedge clock);
            compare_step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic bit b_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
